toggle_event_receiver: RTL and testbench

Receiving end of the toggle-signalling link driven by the team's T flip-flop event source: the sender flips one wire per event; this block synchronizes that wire into the local clock domain and decodes each transition back into one discrete event. Detected events are queued in a saturating pending counter and handed to the consumer over a valid/ready handshake. It sits at the boundary between an event producer, possibly asynchronous, and local control logic.

---
 rtl/toggle_event_receiver.sv | 108 ++++++++++
 tb/tb_toggle_event_receiver.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/toggle_event_receiver.sv
// Receiver for a toggle-signalled event link: synchronizes the toggle wire,
// decodes each level change into an event and queues it for a valid/ready consumer.
module toggle_event_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tog_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             armed
);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int                FILL_W    = 3;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_e                 state_q, state_d;
  logic [FILL_W-1:0]      fill_cnt_q, fill_cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       pending_q, pending_d;
  logic                   overflow_q, overflow_d;
  logic                   armed_q, armed_d;

  logic sync_out;
  logic edge_det;
  logic inc;
  logic dec;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign edge_det  = sync_out ^ prev_q;
  assign evt_valid = (pending_q != '0);
  assign inc       = (state_q == ST_RUN) && edge_det;
  assign dec       = evt_valid && evt_ready;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    sync_d     = {sync_q[SYNC_STAGES-2:0], tog_in};
    prev_d     = prev_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    armed_d    = armed_q;

    unique case (state_q)
      ST_FILL: begin
        fill_cnt_d = fill_cnt_q + 1'b1;
        // Baseline is whatever the synchronizer settled to; no event is raised for it.
        if (fill_cnt_q == FILL_LAST) begin
          prev_d  = sync_out;
          state_d = ST_RUN;
          armed_d = 1'b1;
        end
      end
      ST_RUN: begin
        prev_d = sync_out;
      end
      default: state_d = ST_FILL;
    endcase

    if (ovf_clr) overflow_d = 1'b0;

    // A simultaneous accept makes room, so inc && dec never counts as a loss.
    if (inc && !dec) begin
      if (pending_q == CNT_MAX) overflow_d = 1'b1;
      else                      pending_d  = pending_q + 1'b1;
    end else if (dec && !inc) begin
      pending_d = pending_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_FILL;
      fill_cnt_q <= '0;
      sync_q     <= '0;
      prev_q     <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      armed_q    <= armed_d;
    end
  end

  assign pending  = pending_q;
  assign overflow = overflow_q;
  assign armed    = armed_q;

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Directed self-checking bench for toggle_event_receiver (SYNC_STAGES=2, CNT_W=3).
module tb_toggle_event_receiver;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 3;

  logic             clk = 1'b0;
  logic             rstn;
  logic             tog_in;
  logic             evt_valid;
  logic             evt_ready;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic             ovf_clr;
  logic             armed;

  int n_checks = 0;
  int n_fail   = 0;

  toggle_event_receiver #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .tog_in   (tog_in),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .pending  (pending),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .armed    (armed)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Advance n rising edges; inputs are driven and outputs sampled 1 time unit after each edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Flip the toggle line and wait 4 edges, long enough for the event to be counted.
  task automatic send_event();
    tog_in = ~tog_in;
    tick(4);
  endtask

  task automatic test_reset();
    rstn = 1'b0; tog_in = 1'b1; evt_ready = 1'b0; ovf_clr = 1'b0;
    tick(2);
    n_checks++; if (pending !== 3'd0) begin n_fail++; $display("FAIL reset_pending: got %0d expected 0", pending); end
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
    n_checks++; if (armed !== 1'b0) begin n_fail++; $display("FAIL reset_armed: got %b expected 0", armed); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    rstn = 1'b1;
    tick(2);
    n_checks++; if (armed !== 1'b0) begin n_fail++; $display("FAIL arm_early: got %b expected 0 after edge 2", armed); end
    tick(1);
    n_checks++; if (armed !== 1'b1) begin n_fail++; $display("FAIL arm_edge3: got %b expected 1", armed); end
    tick(4);
    n_checks++; if (pending !== 3'd0) begin n_fail++; $display("FAIL arm_no_spurious: got %0d expected 0", pending); end
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL arm_valid: got %b expected 0", evt_valid); end
  endtask

  task automatic test_single_event();
    tog_in = 1'b0;
    tick(2);
    n_checks++; if (pending !== 3'd0) begin n_fail++; $display("FAIL single_latency: got %0d expected 0 after edge n+1", pending); end
    tick(1);
    n_checks++; if (pending !== 3'd1) begin n_fail++; $display("FAIL single_pending: got %0d expected 1", pending); end
    n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", evt_valid); end
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    n_checks++; if (pending !== 3'd0) begin n_fail++; $display("FAIL single_consume: got %0d expected 0", pending); end
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b expected 0", evt_valid); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 7; i++) send_event();
    n_checks++; if (pending !== 3'd7) begin n_fail++; $display("FAIL sat_seven: got %0d expected 7", pending); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL sat_no_ovf_yet: got %b expected 0", overflow); end
    send_event();
    n_checks++; if (pending !== 3'd7) begin n_fail++; $display("FAIL sat_hold: got %0d expected 7", pending); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_ovf_set: got %b expected 1", overflow); end
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL sat_ovf_clr: got %b expected 0", overflow); end
  endtask

  task automatic test_simultaneous();
    // Toggle before edge n; the increment lands on edge n+2, where the accept is raised.
    tog_in = ~tog_in;
    tick(2);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    n_checks++; if (pending !== 3'd7) begin n_fail++; $display("FAIL simul_pending: got %0d expected 7", pending); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL simul_no_ovf: got %b expected 0", overflow); end
    tick(2);
    tog_in = ~tog_in;
    tick(2);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL set_beats_clr: got %b expected 1", overflow); end
    n_checks++; if (pending !== 3'd7) begin n_fail++; $display("FAIL set_beats_clr_pending: got %0d expected 7", pending); end
  endtask

  task automatic test_reset_mid();
    evt_ready = 1'b1;
    tick(2);
    evt_ready = 1'b0;
    n_checks++; if (pending !== 3'd5) begin n_fail++; $display("FAIL mid_pre_pending: got %0d expected 5", pending); end
    rstn = 1'b0;
    #1;
    n_checks++; if (pending !== 3'd0) begin n_fail++; $display("FAIL mid_pending: got %0d expected 0", pending); end
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", evt_valid); end
    n_checks++; if (armed !== 1'b0) begin n_fail++; $display("FAIL mid_armed: got %b expected 0", armed); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_overflow: got %b expected 0", overflow); end
    #2;
    rstn = 1'b1;
    tick(2);
    n_checks++; if (armed !== 1'b0) begin n_fail++; $display("FAIL rearm_early: got %b expected 0", armed); end
    tick(1);
    n_checks++; if (armed !== 1'b1) begin n_fail++; $display("FAIL rearm: got %b expected 1", armed); end
    tick(4);
    n_checks++; if (pending !== 3'd0) begin n_fail++; $display("FAIL rearm_no_event: got %0d expected 0", pending); end
  endtask

  task automatic test_drain();
    logic [CNT_W-1:0] exp_seq [4];
    logic             rdy_seq [4];
    exp_seq = '{3'd3, 3'd3, 3'd2, 3'd1};
    rdy_seq = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) send_event();
    n_checks++; if (pending !== 3'd4) begin n_fail++; $display("FAIL drain_queued: got %0d expected 4", pending); end
    for (int i = 0; i < 4; i++) begin
      evt_ready = rdy_seq[i];
      tick(1);
      n_checks++; if (pending !== exp_seq[i]) begin n_fail++; $display("FAIL drain_step%0d: got %0d expected %0d", i, pending, exp_seq[i]); end
      n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid%0d: got %b expected 1", i, evt_valid); end
    end
    // Last event with ready held: valid lasts exactly one more cycle, and no wrap below zero.
    tick(1);
    n_checks++; if (pending !== 3'd0) begin n_fail++; $display("FAIL drain_last: got %0d expected 0", pending); end
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid_end: got %b expected 0", evt_valid); end
    tick(2);
    evt_ready = 1'b0;
    n_checks++; if (pending !== 3'd0) begin n_fail++; $display("FAIL no_underflow: got %0d expected 0", pending); end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_saturation();
    test_simultaneous();
    test_reset_mid();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
